add16: RTL and testbench

- Registered 16-bit binary adder. It is the arithmetic leaf of the datapath, used by the incrementer/ALU layer.
- The sum is formed by a ripple chain of full adders (half-adder/full-adder gate structure). The sum and carry are captured in an output register on each clock edge.
- Result is modulo 2^16; the carry-out is exported separately so that callers can detect wrap-around.

---
 rtl/add16.sv | 59 +++++
 tb/tb_add16.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/add16.sv
// Registered WIDTH-bit ripple-carry adder built from gate-level full adders.
// Latency 1 cycle, one operand pair per cycle, no backpressure (in_valid only).
module add16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             out_valid
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   logic [WIDTH-1:0] out_d, out_q;
   logic             cout_d, cout_q;
   logic             out_valid_d, out_valid_q;

   // Bit 0 is a full adder with carry-in tied low, i.e. a half adder.
   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic p;
      assign p          = a[i] ^ b[i];
      assign sum[i]     = p ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & p);
   end

   always_comb begin
      out_d       = out_q;
      cout_d      = cout_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         out_d  = sum;
         cout_d = carry[WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add16.sv
// Self-checking bench for add16: directed vector table, hold and async-reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_add16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] out;
   logic        cout;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_out;
      logic        exp_cout;
   } vec_t;

   vec_t vecs[6];

   add16 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out       (out),
      .cout      (cout),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain 17-bit integer addition.
   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y);
      int unsigned s;
      s = int'(x) + int'(y);
      return s[16:0];
   endfunction

   logic [15:0] m_out;
   logic        m_cout;
   logic        m_vld;
   logic [16:0] r;
   logic [15:0] ra, rb;
   logic        rv;

   initial begin
      vecs[0] = '{16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
      vecs[2] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
      vecs[3] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
      vecs[4] = '{16'h3CC3, 16'h0FF0, 16'h4CB3, 1'b0};
      vecs[5] = '{16'h1234, 16'h9876, 16'hAAAA, 1'b0};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = 16'h0;
      b        = 16'h0;

      // Reset held across clock edges
      repeat (3) step();
      check("reset_out", {1'b0, out}, 17'h0);
      check("reset_cout", {16'h0, cout}, 17'h0);
      check("reset_vld", {16'h0, out_valid}, 17'h0);

      rst_n    = 1'b1;
      in_valid = 1'b1;
      step();
      check("zero_out", {1'b0, out}, 17'h0);
      check("zero_cout", {16'h0, cout}, 17'h0);
      check("zero_vld", {16'h0, out_valid}, 17'h1);

      // Back-to-back table; previous result must persist until the next edge.
      m_out  = 16'h0;
      m_cout = 1'b0;
      for (int i = 0; i < 6; i++) begin
         a = vecs[i].a;
         b = vecs[i].b;
         #1;
         check("pre_edge_out", {cout, out}, {m_cout, m_out});
         step();
         check($sformatf("vec%0d_sum", i), {cout, out}, {vecs[i].exp_cout, vecs[i].exp_out});
         check($sformatf("vec%0d_vld", i), {16'h0, out_valid}, 17'h1);
         m_out  = vecs[i].exp_out;
         m_cout = vecs[i].exp_cout;
      end

      // Hold: invalid input with changing operands must not disturb the result
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      step();
      check("hold_sum", {cout, out}, {1'b0, 16'hAAAA});
      check("hold_vld", {16'h0, out_valid}, 17'h0);
      a = 16'($urandom);
      b = 16'($urandom);
      step();
      check("hold2_sum", {cout, out}, {1'b0, 16'hAAAA});

      // Async reset between edges
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      step();
      check("pre_rst_sum", {cout, out}, {1'b1, 16'hFFFE});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sum", {cout, out}, 17'h0);
      check("async_rst_vld", {16'h0, out_valid}, 17'h0);
      a = 16'h1111;
      b = 16'h2222;
      step();
      check("in_rst_sum", {cout, out}, 17'h0);
      check("in_rst_vld", {16'h0, out_valid}, 17'h0);
      rst_n = 1'b1;
      a = 16'h8000;
      b = 16'h8000;
      step();
      check("post_rst_sum", {cout, out}, {1'b1, 16'h0000});
      check("post_rst_vld", {16'h0, out_valid}, 17'h1);
      a = 16'h7FFF;
      b = 16'h0001;
      step();
      check("post_rst2_sum", {cout, out}, {1'b0, 16'h8000});

      // Randomized traffic; every accepted pair is re-sent swapped next cycle.
      m_out  = 16'h8000;
      m_cout = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rv = 1'($urandom_range(0, 3) != 0);
         a = ra;
         b = rb;
         in_valid = rv;
         step();
         if (rv) begin
            r = ref_add(ra, rb);
            m_out  = r[15:0];
            m_cout = r[16];
         end
         m_vld = rv;
         check("rand_sum", {cout, out}, {m_cout, m_out});
         check("rand_vld", {16'h0, out_valid}, {16'h0, m_vld});
         if (rv) begin
            a = rb;
            b = ra;
            step();
            r = ref_add(rb, ra);
            check("swap_sum", {cout, out}, r);
            check("swap_vld", {16'h0, out_valid}, 17'h1);
            m_out  = r[15:0];
            m_cout = r[16];
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
